// File: rtl/pool_arb_pkg.sv
// Shared definitions for the pooling-datapath arbiter.
// Holds the FSM state encoding and the frame geometry helpers.
// No logic, so no latency or backpressure behaviour of its own.
package pool_arb_pkg;

    // FSM state encoding, plain constants so older tools and waveform
    // scripts that expect fixed codes keep working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;

    // Pixels carried by one frame.
    function automatic int pix_per_frame(input int line_w, input int line_c);
        return line_w * line_c;
    endfunction

    // Pooled results produced by one frame (valid kernel positions only).
    function automatic int out_per_frame(input int line_w, input int line_c,
                                         input int kernel_w, input int stride);
        return ((line_w - kernel_w) / stride + 1) * ((line_c - kernel_w) / stride + 1);
    endfunction

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_arb_rr_select.sv
// Round-robin pick: first asserted request at or after last+1, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides when a grant is taken.
//
// Ports: req  - request vector
//        last - index of the previous winner (search starts one above it)
//        gnt  - one-hot grant, all zero when no request is pending
//        idx  - binary index of the granted requester
module rr_select #(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // Walk N positions starting just past the last winner; the first
        // asserted request wins, so the previous owner is tried last.
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/pool_arb.sv
// Frame-granular arbiter sharing one pooling datapath among NumReq pixel sources.
// Zero-latency combinational pixel and result paths; grant takes one cycle in IDLE.
// Owner's ready mirrors pool_ready_i; non-owners see ready low; results obey ready_i.
//
// Ports: clk_i/rst_ni (async active-low reset); req_valid_i/req_ready_o/req_data_i
//        per-requester pixel streams; pool_valid_o/pool_ready_i/pool_data_o pixels to
//        the datapath; pool_valid_i/pool_ready_o/pool_data_i pooled results back;
//        valid_o/ready_i/data_o/id_o tagged results; frame_done_o final-result pulse.
// Optional: define POOL_ARB_PERF_EN to add frames_o, a 16-bit wrapping count of
//           completed frames per requester.
module pool_arb
    import pool_arb_pkg::*;
#(
    parameter int NumReq      = 2,
    parameter int LineWidthPx = 16,
    parameter int LineCountPx = 12,
    parameter int KernelWidth = 3,
    parameter int Stride      = KernelWidth,
    parameter int InChannels  = 1,
    parameter int WidthIn     = 1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NumReq-1:0]                              req_valid_i,
    output logic [NumReq-1:0]                              req_ready_o,
    input  logic [NumReq-1:0][InChannels*WidthIn-1:0]      req_data_i,
    output logic                                           pool_valid_o,
    input  logic                                           pool_ready_i,
    output logic [InChannels*WidthIn-1:0]                  pool_data_o,
    input  logic                                           pool_valid_i,
    output logic                                           pool_ready_o,
    input  logic [InChannels*WidthIn-1:0]                  pool_data_i,
    output logic                                           valid_o,
    input  logic                                           ready_i,
    output logic [InChannels*WidthIn-1:0]                  data_o,
    output logic [idx_w(NumReq)-1:0]                       id_o,
    output logic                                           frame_done_o
`ifdef POOL_ARB_PERF_EN
    ,
    output logic [NumReq-1:0][15:0]                        frames_o
`endif
);

    localparam int IdxW        = idx_w(NumReq);
    localparam int PixPerFrame = pix_per_frame(LineWidthPx, LineCountPx);
    localparam int OutPerFrame = out_per_frame(LineWidthPx, LineCountPx, KernelWidth, Stride);
    localparam int PixW        = $clog2(PixPerFrame);
    localparam int ResW        = $clog2(OutPerFrame + 1);
    localparam logic [PixW-1:0] PixLast = PixW'(PixPerFrame - 1);
    localparam logic [ResW-1:0] ResLast = ResW'(OutPerFrame - 1);

    state_t          state;
    logic [IdxW-1:0] owner;
    logic            seeded;     // low until the first grant after reset
    logic [PixW-1:0] pix_cnt;
    logic [ResW-1:0] res_cnt;

    logic [NumReq-1:0] rr_gnt;
    logic [IdxW-1:0]   rr_idx;
    logic [IdxW-1:0]   rr_last;

    logic pix_fire;
    logic res_cnt_fire;
    logic last_res;

    // Before any grant the search must begin at index 0, so present the
    // highest index as the previous winner while owner itself stays 0.
    assign rr_last = seeded ? owner : IdxW'(NumReq - 1);

    rr_select #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr_select (
        .req  (req_valid_i),
        .last (rr_last),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    // Pixel path: only the owner is connected, and only while streaming.
    always_comb begin
        pool_valid_o = 1'b0;
        req_ready_o  = '0;
        pool_data_o  = req_data_i[owner];
        if (state == ST_STREAM) begin
            pool_valid_o       = req_valid_i[owner];
            req_ready_o[owner] = pool_ready_i;
        end
    end

    // Result path is wired through in every state; a result seen in IDLE
    // still passes (tagged with the previous owner) but is not counted.
    assign valid_o      = pool_valid_i;
    assign pool_ready_o = ready_i;
    assign data_o       = pool_data_i;
    assign id_o         = owner;

    assign pix_fire     = pool_valid_o & pool_ready_i;
    assign res_cnt_fire = valid_o & ready_i & (state != ST_IDLE);
    assign last_res     = res_cnt_fire & (res_cnt == ResLast);
    assign frame_done_o = last_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            owner   <= '0;
            seeded  <= 1'b0;
            pix_cnt <= '0;
            res_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|rr_gnt) begin
                        owner  <= rr_idx;
                        seeded <= 1'b1;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Final result wins even if the final pixel fires with it.
                    if (last_res) begin
                        state   <= ST_IDLE;
                        pix_cnt <= '0;
                        res_cnt <= '0;
                    end else begin
                        if (res_cnt_fire) begin
                            res_cnt <= res_cnt + 1'b1;
                        end
                        // Counter holds at its last value in DRAIN; it never wraps.
                        if (pix_fire) begin
                            if (pix_cnt == PixLast) begin
                                state <= ST_DRAIN;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_res) begin
                        state   <= ST_IDLE;
                        pix_cnt <= '0;
                        res_cnt <= '0;
                    end else if (res_cnt_fire) begin
                        res_cnt <= res_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef POOL_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frames_o <= '0;
        end else if (frame_done_o) begin
            frames_o[owner] <= frames_o[owner] + 16'd1;
        end
    end
`else
    // Completed-frame counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pool_arb.sv
// Directed bench for pool_arb with default parameters (2 requesters, 192 px, 20 results).
// Drives and samples at negedge (+1) so the DUT sees stable inputs at posedge.
// The bench stands in for both the pixel sources and the pooling datapath.
module tb_pool_arb;

    localparam int NPIX = 192;
    localparam int NRES = 20;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [1:0][0:0] req_data_i;
    logic            pool_valid_o;
    logic            pool_ready_i;
    logic [0:0]      pool_data_o;
    logic            pool_valid_i;
    logic            pool_ready_o;
    logic [0:0]      pool_data_i;
    logic            valid_o;
    logic            ready_i;
    logic [0:0]      data_o;
    logic [0:0]      id_o;
    logic            frame_done_o;
`ifdef POOL_ARB_PERF_EN
    logic [1:0][15:0] frames_o;
`endif

    int total = 0;
    int bad   = 0;
    int fmodel [2];

    always #5 clk_i = ~clk_i;

    pool_arb dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .pool_valid_o (pool_valid_o),
        .pool_ready_i (pool_ready_i),
        .pool_data_o  (pool_data_o),
        .pool_valid_i (pool_valid_i),
        .pool_ready_o (pool_ready_o),
        .pool_data_i  (pool_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .id_o         (id_o),
        .frame_done_o (frame_done_o)
`ifdef POOL_ARB_PERF_EN
        ,
        .frames_o     (frames_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Stream npix pixels from requester own; the first cycle(s) may be IDLE.
    task automatic run_pixels(input int own, input int npix, input bit rnd_rdy);
        int         pix     = 0;
        int         cyc     = 0;
        int         bad_rdy = 0;
        int         bad_dat = 0;
        int         bad_id  = 0;
        logic [1:0] mask;
        mask = 2'(1 << own);
        while (pix < npix && cyc < 4000) begin
            @(negedge clk_i);
            req_data_i[0] = 1'(cyc);
            req_data_i[1] = ~1'(cyc);
            pool_ready_i  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if ((req_ready_o & ~mask) != 2'b00) bad_rdy++;
            if (pool_valid_o) begin
                if (req_ready_o[own] !== pool_ready_i) bad_rdy++;
                if (pool_data_o !== req_data_i[own]) bad_dat++;
                if (id_o !== 1'(own)) bad_id++;
                if (pool_ready_i) pix++;
            end
            cyc++;
        end
        check("pixel_count", pix, npix);
        check("ready_routing", bad_rdy, 0);
        check("pixel_data", bad_dat, 0);
        check("owner_id", bad_id, 0);
    endtask

    // Feed NRES results while the FSM drains; ready_i random when bp is set.
    task automatic run_drain(input int own, input bit bp);
        int   fires    = 0;
        int   cyc      = 0;
        int   fd       = 0;
        int   bad_fd   = 0;
        int   bad_q    = 0;
        int   bad_pass = 0;
        logic exp_fd;
        while (fires < NRES && cyc < 1000) begin
            @(negedge clk_i);
            pool_valid_i = 1'b1;
            pool_data_i  = 1'(fires);
            ready_i      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pool_valid_o || req_ready_o != 2'b00) bad_q++;
            if (valid_o !== 1'b1 || data_o !== pool_data_i || id_o !== 1'(own) ||
                pool_ready_o !== ready_i) bad_pass++;
            exp_fd = ready_i && (fires == NRES - 1);
            if (frame_done_o !== exp_fd) bad_fd++;
            if (frame_done_o) fd++;
            if (ready_i) fires++;
            cyc++;
        end
        check("result_count", fires, NRES);
        check("drain_no_grant", bad_q, 0);
        check("result_pass", bad_pass, 0);
        check("done_timing", bad_fd, 0);
        check("done_pulses", fd, 1);
        fmodel[own]++;
        @(negedge clk_i);
        pool_valid_i = 1'b0;
        ready_i      = 1'b1;
        #1;
        check("idle_quiet", {pool_valid_o, req_ready_o, frame_done_o}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        fmodel[0] = 0;
        fmodel[1] = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 2'b11;
        req_data_i   = '0;
        pool_ready_i = 1'b1;
        pool_valid_i = 1'b0;
        pool_data_i  = '0;
        ready_i      = 1'b1;
        fmodel[0]    = 0;
        fmodel[1]    = 0;

        // Reset holds everything quiet even with both requesters valid.
        @(negedge clk_i);
        #1;
        check("rst_req_ready", req_ready_o, 0);
        check("rst_pool_valid", pool_valid_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_id", id_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single requester.
        req_valid_i = 2'b01;
        run_pixels(0, NPIX, 1'b0);
        run_drain(0, 1'b0);

        // Contention from reset: req 0 first, then req 1 (with drain backpressure).
        pulse_reset();
        req_valid_i = 2'b11;
        run_pixels(0, NPIX, 1'b1);
        run_drain(0, 1'b0);
        run_pixels(1, NPIX, 1'b0);
        run_drain(1, 1'b1);

        // Stray result in IDLE: passed with previous owner, not counted.
        req_valid_i = 2'b00;
        @(negedge clk_i);
        pool_valid_i = 1'b1;
        pool_data_i  = 1'b1;
        ready_i      = 1'b1;
        #1;
        check("idle_res_valid", valid_o, 1);
        check("idle_res_id", id_o, 1);
        check("idle_res_done", frame_done_o, 0);
        @(negedge clk_i);
        pool_valid_i = 1'b0;

        // Next frame must still need a full NRES results.
        req_valid_i = 2'b01;
        run_pixels(0, NPIX, 1'b0);
        run_drain(0, 1'b1);

        // Mid-frame async reset at pixel 100 of a req 1 frame.
        req_valid_i = 2'b10;
        run_pixels(1, 100, 1'b0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        fmodel[0] = 0;
        fmodel[1] = 0;
        #1;
        check("async_rst_ready", req_ready_o, 0);
        check("async_rst_valid", pool_valid_o, 0);
        check("async_rst_id", id_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // After reset the grant restarts at req 0 with cleared counters,
        // then frames alternate 0/1/0.
        req_valid_i = 2'b11;
        run_pixels(0, NPIX, 1'b0);
        run_drain(0, 1'b0);
        run_pixels(1, NPIX, 1'b0);
        run_drain(1, 1'b0);
        run_pixels(0, NPIX, 1'b0);
        run_drain(0, 1'b0);

`ifdef POOL_ARB_PERF_EN
        check("frames_req0", frames_o[0], 32'(fmodel[0]));
        check("frames_req1", frames_o[1], 32'(fmodel[1]));
        check("frames_req0_abs", frames_o[0], 2);
        check("frames_req1_abs", frames_o[1], 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
